// File: rtl/mips_isa_pkg.sv
// Shared MIPS-CA-Lab ISA definitions: opcodes, field positions, format enum
// and the instruction loader FSM state encoding.
package mips_isa_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_XOR  = 6'd7;
    localparam logic [5:0] OP_NOR  = 6'd8;
    localparam logic [5:0] OP_SLT  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRL  = 6'd11;
    localparam logic [5:0] OP_SRA  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LW   = 6'd36;
    localparam logic [5:0] OP_SW   = 6'd37;
    localparam logic [5:0] OP_BEQ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam int OPC_LSB  = 26;
    localparam int DEST_LSB = 21;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 11;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        FMT_NOP,
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_ILLEGAL
    } instr_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational opcode classification and 32-bit instruction word packing.
// Illegal opcodes are packed with the I-type layout; the caller decides whether to use it.
module instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  dest,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [15:0] imm,
    output instr_fmt_t  fmt,
    output logic [31:0] word
);

    always_comb begin
        fmt = FMT_ILLEGAL;
        case (opcode)
            OP_NOP:                                   fmt = FMT_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOR, OP_SLT, OP_SLL, OP_SRL, OP_SRA:   fmt = FMT_R;
            OP_ADDI, OP_SUBI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE:                           fmt = FMT_I;
            OP_JMP:                                   fmt = FMT_J;
            default:                                  fmt = FMT_ILLEGAL;
        endcase
    end

    always_comb begin
        word = 32'h0;
        case (fmt)
            FMT_NOP: word = 32'h0;
            FMT_R:   word = {opcode, dest, src1, src2, 11'b0};
            FMT_J:   word = {opcode, 10'b0, imm};
            default: word = {opcode, dest, src1, imm};
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Load-session FSM: encodes requests into instruction memory, pads the tail with NOPs.
// ENCODER_CHECK_EN: illegal opcodes are rejected and counted instead of being written.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_dest,
    input  logic [4:0]        in_src1,
    input  logic [4:0]        in_src2,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_pulse,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   word_count
);

`ifdef ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int              LAST_I    = DEPTH - 1;
    localparam logic [ADDR_W:0] LAST_ADDR = LAST_I[ADDR_W:0];

    load_state_t       state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    instr_fmt_t  pack_fmt;
    logic [31:0] pack_word;
    logic        accept, reject, write_req;

    instr_field_pack u_pack (
        .opcode (in_opcode),
        .dest   (in_dest),
        .src1   (in_src1),
        .src2   (in_src2),
        .imm    (in_imm),
        .fmt    (pack_fmt),
        .word   (pack_word)
    );

    assign accept    = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign reject    = accept && CHECK_EN && (pack_fmt == FMT_ILLEGAL);
    assign write_req = accept && !reject;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    addr_d       = '0;
                    word_count_d = '0;
                    err_count_d  = '0;
                end
            end
            ST_LOAD: begin
                if (write_req) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = addr_q[ADDR_W-1:0];
                    mem_wdata_d  = pack_word;
                    addr_d       = addr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                end
                if (reject) begin
                    err_pulse_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end
                // A write into the last slot ends the session even if finish is also high.
                if (write_req && (addr_q == LAST_ADDR)) state_d = ST_DONE;
                else if (finish)                        state_d = ST_PAD;
            end
            ST_PAD: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q[ADDR_W-1:0];
                mem_wdata_d = 32'h0;
                addr_d      = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD);
        // done lags entry into DONE by a cycle so it rises after the final write is visible.
        done_d     = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            done_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= 8'd0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH = 2**ADDR_W = 8): directed sessions checked
// against an expected-write queue built from the encoding and session rules.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
`ifdef ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, finish, in_valid, in_ready;
  logic [5:0] in_opcode;
  logic [4:0] in_dest, in_src1, in_src2;
  logic [15:0] in_imm;
  logic mem_we, done, err_pulse;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0] err_count;
  logic [ADDR_W:0] word_count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  typedef struct {
    int due;
    int addr;
    logic [31:0] data;
    int wc;
  } wr_t;
  typedef struct {
    int due;
    int ec;
  } er_t;
  wr_t exp_q[$];
  er_t err_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  m_addr = 0, m_words = 0, m_errs = 0;
  bit  m_load = 0;
  bit  done_pending = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  // model: returns {legal, word}
  function automatic logic [32:0] model_encode(int op, int d, int s1, int s2, int imm);
    logic [5:0] o;
    logic [4:0] dd, a, b;
    logic [15:0] im;
    o = op[5:0]; dd = d[4:0]; a = s1[4:0]; b = s2[4:0]; im = imm[15:0];
    case (op)
      0: return {1'b1, 32'h0};
      1, 3, 5, 6, 7, 8, 9, 10, 11, 12: return {1'b1, o, dd, a, b, 11'b0};
      32, 33, 36, 37, 40, 41: return {1'b1, o, dd, a, im};
      42: return {1'b1, o, 10'b0, im};
      default: return {1'b0, o, dd, a, im};
    endcase
  endfunction

  function automatic void push_pads(int first_due);
    wr_t e;
    for (int a = m_addr; a < DEPTH; a++) begin
      e.due = first_due + (a - m_addr); e.addr = a; e.data = 32'h0; e.wc = m_words;
      exp_q.push_back(e);
    end
    m_addr = DEPTH;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      if (done_pending) begin
        check("done_after_last_write", done, 1);
        done_pending = 0;
      end
      if (mem_we) begin
        check("done_low_while_writing", done, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_write: addr %0d data %0h, required no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.due));
          check("write_addr", 64'(mem_addr), 64'(e.addr));
          check("write_data", 64'(mem_wdata), 64'(e.data));
          check("word_count", 64'(word_count), 64'(e.wc));
          if (e.addr == DEPTH - 1) done_pending = 1;
        end
      end
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_err_pulse: err_count %0d, required no pulse", err_count);
        end else begin
          er_t r;
          r = err_q.pop_front();
          check("err_cycle", 64'(cyc), 64'(r.due));
          check("err_count", 64'(err_count), 64'(r.ec));
        end
      end
    end
  end

  // driver tasks
  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; finish = 1'b0;
    m_addr = 0; m_words = 0; m_errs = 0; m_load = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(int op, int d, int s1, int s2, int imm, bit fin);
    int w = 0;
    logic [32:0] r;
    wr_t e;
    er_t er;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: in_ready 0, required 1");
      return;
    end
    in_valid = 1'b1; finish = fin;
    in_opcode = op[5:0]; in_dest = d[4:0]; in_src1 = s1[4:0]; in_src2 = s2[4:0]; in_imm = imm[15:0];
    r = model_encode(op, d, s1, s2, imm);
    if (!r[32] && CHK) begin
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
      er.due = cyc + 1; er.ec = m_errs;
      err_q.push_back(er);
    end else begin
      m_words++;
      e.due = cyc + 1; e.addr = m_addr; e.data = r[31:0]; e.wc = m_words;
      exp_q.push_back(e);
      m_addr++;
      if (m_addr == DEPTH) m_load = 0;
    end
    if (fin && m_load) begin
      push_pads(cyc + 2);
      m_load = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic do_finish();
    in_valid = 1'b0; finish = 1'b1;
    if (m_load) begin
      push_pads(cyc + 2);
      m_load = 0;
    end
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 30) begin @(negedge clk); w++; end
    check("done_reached", done, 1);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_count"}, 64'(err_count), 0);
    check({tag, "_word_count"}, 64'(word_count), 0);
  endtask

  task automatic mid_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    exp_q.delete(); err_q.delete(); done_pending = 0; m_load = 0;
    idle();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // stimulus table for the full-memory session
  int full_op[8] = '{5, 6, 7, 8, 33, 36, 0, 41};

  initial begin
    logic [32:0] pin;
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_dest = '0; in_src1 = '0; in_src2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // pin the model against hand-computed words
    pin = model_encode(1, 1, 2, 3, 0);       check("pin_add",  pin, {1'b1, 32'h04221800});
    pin = model_encode(32, 5, 0, 0, 16'h10); check("pin_addi", pin, {1'b1, 32'h80A00010});
    pin = model_encode(42, 0, 0, 0, 16'h4);  check("pin_jmp",  pin, {1'b1, 32'hA8000004});
    pin = model_encode(2, 4, 7, 1, 16'h1234); check("pin_illegal", pin, {1'b0, 32'h08871234});

    // ADD, then early finish: pads 1..7
    do_start();
    send(1, 1, 2, 3, 0, 0);
    idle();
    check("add_we", mem_we, 1);
    check("add_addr", 64'(mem_addr), 0);
    check("add_wdata", 64'(mem_wdata), 64'h04221800);
    check("add_word_count", 64'(word_count), 1);
    @(negedge clk);
    do_finish();
    check("pad_in_ready_low", in_ready, 0);
    wait_done();
    check("early_finish_word_count", 64'(word_count), 1);

    // ADDI, JMP, illegal, then R-type with same-cycle finish
    do_start();
    send(32, 5, 0, 0, 16'h0010, 0);
    send(42, 0, 0, 0, 16'h0004, 0);
    send(2, 4, 7, 1, 16'h1234, 0);
    send(12, 31, 30, 29, 16'hFFFF, 1);
    idle();
    wait_done();
    check("session2_word_count", 64'(word_count), 64'(m_words));
    check("session2_err_count", 64'(err_count), 64'(m_errs));

    // illegal opcode as first request
    do_start();
    send(2, 4, 7, 1, 16'h1234, 0);
    idle();
    if (CHK) begin
      check("illegal_no_write", mem_we, 0);
      check("illegal_err_pulse", err_pulse, 1);
      check("illegal_err_count", 64'(err_count), 1);
    end else begin
      check("illegal_written", mem_we, 1);
      check("illegal_addr", 64'(mem_addr), 0);
      check("illegal_word", 64'(mem_wdata), 64'h08871234);
    end
    @(negedge clk);
    check("err_pulse_one_cycle", err_pulse, 0);
    send(3, 2, 2, 2, 0, 0);
    idle();
    check("after_illegal_addr", 64'(mem_addr), CHK ? 0 : 1);
    do_finish();
    wait_done();

    // full memory: in_valid held high, extra request and finish ignored
    do_start();
    for (int i = 0; i < DEPTH; i++) send(full_op[i], i, i + 8, i + 16, 16'h0100 * i + i, 0);
    check("full_in_ready_drop", in_ready, 0);
    in_opcode = 6'd1;
    @(negedge clk);
    do_finish();
    repeat (3) @(negedge clk);
    check("full_done", done, 1);
    check("full_word_count", 64'(word_count), DEPTH);

    // reset mid-LOAD, restart from DONE
    do_start();
    send(1, 1, 1, 1, 0, 0);
    send(9, 2, 3, 4, 0, 0);
    idle();
    mid_reset("rst_load");

    // reset mid-PAD
    do_start();
    send(10, 3, 3, 3, 0, 1);
    idle();
    @(negedge clk);
    @(negedge clk);
    mid_reset("rst_pad");

    // clean restart at addr 0
    do_start();
    send(40, 6, 7, 0, 16'hBEEF, 0);
    idle();
    check("restart_addr", 64'(mem_addr), 0);
    do_finish();
    wait_done();

    @(negedge clk);
    check("exp_queue_drained", 64'(exp_q.size()), 0);
    check("err_queue_drained", 64'(err_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
